// File: rtl/rggen_trigger_arbiter.sv
// Round-robin arbiter that latches one-cycle trigger pulses as pending requests
// and hands them one at a time to a shared engine with a busy timeout.
module rggen_trigger_arbiter #(
    parameter int REQUESTERS    = 4,
    parameter int ID_WIDTH      = 2,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [REQUESTERS-1:0]    i_trigger,
    output logic [REQUESTERS-1:0]    o_pending,
    output logic [REQUESTERS-1:0]    o_overflow,
    input  logic [REQUESTERS-1:0]    i_overflow_clear,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [ID_WIDTH-1:0]      o_id,
    input  logic                     i_done,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
    output logic                     o_busy,
    output logic                     o_timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = TIMEOUT_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0]      LAST_RST = ID_WIDTH'(REQUESTERS - 1);

    logic [1:0]               state_q, state_d;
    logic [REQUESTERS-1:0]    pending_q, pending_d;
    logic [REQUESTERS-1:0]    overflow_q, overflow_d;
    logic                     valid_q, valid_d;
    logic [ID_WIDTH-1:0]      id_q, id_d;
    logic [ID_WIDTH-1:0]      last_q, last_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     timeout_q, timeout_d;

    logic                     accept;
    logic [REQUESTERS-1:0]    grant_clr;
    logic [REQUESTERS-1:0]    ovf_set;
    logic [ID_WIDTH-1:0]      grant_idx;
    int                       best_off;
    int                       off;
    logic [TIMEOUT_WIDTH-1:0] tmo_last;
    logic                     tmo_expire;

    assign accept = (state_q == ST_REQUEST) && i_ready;

    always_comb begin
        grant_clr = '0;
        ovf_set   = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            grant_clr[i] = accept && (id_q == ID_WIDTH'(i));
            // A trigger racing its own acceptance is absorbed as a fresh request.
            ovf_set[i]   = i_trigger[i] && pending_q[i] && !grant_clr[i];
        end
        pending_d  = i_trigger | (pending_q & ~grant_clr);
        overflow_d = ovf_set | (overflow_q & ~i_overflow_clear);
    end

    // Pick the pending index with the smallest distance past the last grant.
    always_comb begin
        best_off  = REQUESTERS;
        off       = 0;
        grant_idx = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            off = i - int'(last_q) - 1;
            if (off < 0) off = off + REQUESTERS;
            if (pending_q[i] && (off < best_off)) begin
                best_off  = off;
                grant_idx = ID_WIDTH'(i);
            end
        end
    end

    assign tmo_last   = i_timeout - CNT_ONE;
    assign tmo_expire = (i_timeout != '0) && (cnt_q == tmo_last);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        id_d      = id_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    valid_d = 1'b1;
                    id_d    = grant_idx;
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    last_d  = id_q;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_done) begin
                    state_d = ST_IDLE;
                end else if (tmo_expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else if ((i_timeout != '0) && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overflow_q <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            last_q     <= LAST_RST;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_pending  = pending_q;
    assign o_overflow = overflow_q;
    assign o_valid    = valid_q;
    assign o_id       = id_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_rggen_trigger_arbiter.sv
// Directed plus random checks of rggen_trigger_arbiter against a cycle-level
// reference model of the pending/grant/timeout rules.
module tb_rggen_trigger_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [3:0] i_trigger;
    logic [3:0] o_pending;
    logic [3:0] o_overflow;
    logic [3:0] i_overflow_clear;
    logic       o_valid;
    logic       i_ready;
    logic [1:0] o_id;
    logic       i_done;
    logic [7:0] i_timeout;
    logic       o_busy;
    logic       o_timeout;

    int checks = 0;
    int errors = 0;

    rggen_trigger_arbiter #(.REQUESTERS(4), .ID_WIDTH(2), .TIMEOUT_WIDTH(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_trigger(i_trigger),
        .o_pending(o_pending), .o_overflow(o_overflow),
        .i_overflow_clear(i_overflow_clear), .o_valid(o_valid),
        .i_ready(i_ready), .o_id(o_id), .i_done(i_done),
        .i_timeout(i_timeout), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: granted = handed out but not yet accepted,
    // in_op = accepted and waiting for done/timeout.
    bit [3:0] m_pend, m_ovf;
    bit       m_granted, m_in_op, m_tout;
    int       m_id, m_last, m_cnt;

    task automatic model_reset();
        m_pend = 0; m_ovf = 0; m_granted = 0; m_in_op = 0; m_tout = 0;
        m_id = 0; m_last = 3; m_cnt = 0;
    endtask

    task automatic model_clock(input bit [3:0] trig, input bit ready, input bit done,
                               input bit [3:0] clr);
        bit [3:0] np, setm;
        bit       taken;
        np = m_pend; setm = 0;
        for (int i = 0; i < 4; i++) begin
            taken = m_granted && ready && (m_id == i);
            if (trig[i]) begin
                if (m_pend[i] && !taken) setm[i] = 1;
                np[i] = 1;
            end else if (taken) begin
                np[i] = 0;
            end
        end
        m_tout = 0;
        if (m_in_op) begin
            if (done) m_in_op = 0;
            else if (i_timeout != 0) begin
                if (m_cnt == int'(i_timeout) - 1) begin m_in_op = 0; m_tout = 1; end
                else if (m_cnt < 255) m_cnt++;
            end
        end else if (m_granted) begin
            if (ready) begin m_granted = 0; m_in_op = 1; m_last = m_id; m_cnt = 0; end
        end else if (m_pend != 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_pend[(m_last + k) % 4]) begin m_id = (m_last + k) % 4; break; end
            end
            m_granted = 1;
        end
        m_ovf  = (m_ovf & ~clr) | setm;
        m_pend = np;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("pending", 32'(o_pending), 32'(m_pend));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("valid", 32'(o_valid), 32'(m_granted));
        chk("id", 32'(o_id), 32'(m_id));
        chk("busy", 32'(o_busy), 32'(m_granted | m_in_op));
        chk("timeout", 32'(o_timeout), 32'(m_tout));
    endtask

    task automatic step(input bit [3:0] trig, input bit ready, input bit done, input bit [3:0] clr);
        i_trigger = trig; i_ready = ready; i_done = done; i_overflow_clear = clr;
        @(posedge i_clk);
        model_clock(trig, ready, done, clr);
        #1;
        compare_all();
        i_trigger = 0; i_ready = 0; i_done = 0; i_overflow_clear = 0;
    endtask

    task automatic do_reset();
        i_rst_n = 0; i_trigger = 0; i_ready = 0; i_done = 0; i_overflow_clear = 0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1;
        compare_all();
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 10 && !o_valid; n++) step(0, 0, 0, 0);
        chk("valid_wait", 32'(o_valid), 1);
    endtask

    // One full operation: handshake, busy_trig on the first busy cycle,
    // done three cycles after the grant.
    task automatic serve(output int id, input bit [3:0] busy_trig);
        wait_valid();
        id = int'(o_id);
        step(0, 1, 0, 0);
        step(busy_trig, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
    endtask

    int id;

    initial begin
        i_rst_n = 0; i_trigger = 0; i_ready = 0; i_done = 0;
        i_overflow_clear = 0; i_timeout = 0;
        do_reset();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);

        // Single request latency and handshake
        step(4'b0001, 0, 0, 0);
        chk("pend0_set", 32'(o_pending), 32'h1);
        chk("no_valid_yet", 32'(o_valid), 0);
        step(0, 1, 0, 0);
        chk("valid_2cyc", 32'(o_valid), 1);
        chk("id0", 32'(o_id), 0);
        step(0, 1, 0, 0);
        chk("pend0_clr", 32'(o_pending), 0);
        chk("busy_after_hs", 32'(o_busy), 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("idle_after_done", 32'(o_busy), 0);

        // All four at once from reset: order 0,1,2,3
        do_reset();
        step(4'b1111, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            serve(id, 0);
            chk("rr_order", 32'(id), 32'(k));
        end
        chk("rr_no_ovf", 32'(o_overflow), 0);

        // Grant 1, retrigger 0,1,3 while busy: order 3, 0, 1
        step(4'b0010, 0, 0, 0);
        serve(id, 4'b1011);
        chk("grant1", 32'(id), 1);
        serve(id, 0); chk("wrap_3", 32'(id), 3);
        serve(id, 0); chk("wrap_0", 32'(id), 0);
        serve(id, 0); chk("wrap_1", 32'(id), 1);
        chk("wrap_no_ovf", 32'(o_overflow), 0);

        // Overflow on bit 2 while another requester is busy
        step(4'b0001, 0, 0, 0);
        wait_valid();
        step(0, 1, 0, 0);
        step(4'b0100, 0, 0, 0);
        step(4'b0100, 0, 0, 0);
        chk("ovf_set", 32'(o_overflow), 32'h4);
        step(4'b0100, 0, 0, 4'b0100);
        chk("ovf_set_wins", 32'(o_overflow), 32'h4);
        step(0, 0, 0, 4'b0100);
        chk("ovf_cleared", 32'(o_overflow), 0);
        step(0, 0, 1, 0);
        serve(id, 0);
        chk("grant2", 32'(id), 2);

        // Timeout of 5 cycles after the handshake edge
        i_timeout = 8'd5;
        step(4'b0001, 0, 0, 0);
        wait_valid();
        step(0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 0);
            chk("tmo_early", 32'(o_timeout), 0);
        end
        step(0, 0, 0, 0);
        chk("tmo_pulse", 32'(o_timeout), 1);
        chk("tmo_idle", 32'(o_busy), 0);
        step(0, 0, 0, 0);
        chk("tmo_one_cycle", 32'(o_timeout), 0);

        // Timeout disabled: stays busy
        i_timeout = 8'd0;
        step(4'b0001, 0, 0, 0);
        wait_valid();
        step(0, 1, 0, 0);
        repeat (40) step(0, 0, 0, 0);
        chk("no_tmo_busy", 32'(o_busy), 1);
        step(0, 0, 1, 0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) i_timeout = 8'($urandom_range(0, 3) * 3);
            step(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
        end

        // Asynchronous reset with a live grant and pending 1010
        i_timeout = 0;
        do_reset();
        step(4'b1010, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_rst_valid", 32'(o_valid), 1);
        chk("pre_rst_pend", 32'(o_pending), 32'hA);
        #2 i_rst_n = 0;
        #1;
        chk("arst_valid", 32'(o_valid), 0);
        chk("arst_pend", 32'(o_pending), 0);
        chk("arst_busy", 32'(o_busy), 0);
        model_reset();
        #3 i_rst_n = 1;
        repeat (5) step(0, 0, 0, 0);
        chk("no_regrant", 32'(o_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
